// File: rtl/bit_scan_serializer_pkg.sv
// Shared definitions for the bit-scan serializer: state encoding and
// default mask/index widths.
package bit_scan_serializer_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int IDXW_DEF  = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/bit_scan_serializer_lsb_finder.sv
// Combinational bit-vector analysis: lowest set bit index, any-set flag
// (built as a balanced OR tree), and exactly-one-set flag.
module or_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module lsb_finder
    import bit_scan_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             any,
    output logic             single
);

    // Heap-ordered tree: node i combines nodes 2i and 2i+1; leaves sit at WIDTH..2*WIDTH-1.
    logic [2*WIDTH-1:1] w_node;

    for (genvar j = 0; j < WIDTH; j++) begin : g_leaf
        assign w_node[WIDTH+j] = vec[j];
    end

    for (genvar n = 1; n < WIDTH; n++) begin : g_or
        or_gate u_or (
            .a (w_node[2*n]),
            .b (w_node[2*n+1]),
            .y (w_node[n])
        );
    end

    assign any = w_node[1];

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign single = any && ((vec & (vec - WIDTH'(1))) == '0);

    // Scanning downward lets the lowest set bit win the last assignment.
    // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDXW'(i);
        end
    end

endmodule

// File: rtl/bit_scan_serializer.sv
// Expands an accepted bit mask into a stream of set-bit indices, lowest
// first, one per out_valid/out_ready handshake.
module bit_scan_serializer
    import bit_scan_serializer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             zero_mask,
    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_pending;
    logic             r_zero_mask;

    logic [IDXW-1:0]  w_idx;
    logic             w_any;
    logic             w_single;
    logic             w_accept;

    lsb_finder #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_finder (
        .vec    (r_pending),
        .idx    (w_idx),
        .any    (w_any),
        .single (w_single)
    );

    // Outputs derive only from registered state; in_ready also drops during reset.
    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_SCAN) && w_any;
    assign out_idx   = w_idx;
    assign out_last  = (r_state == S_SCAN) && w_single;
    assign zero_mask = r_zero_mask;
    assign busy      = (r_state == S_SCAN);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_zero_mask <= 1'b0;
        end else begin
            r_zero_mask <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_mask != '0) begin
                            r_pending <= in_mask;
                            r_state   <= S_SCAN;
                        end else begin
                            r_zero_mask <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (out_ready) begin
                        r_pending[w_idx] <= 1'b0;
                        if (w_single) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Directed and randomized bench for bit_scan_serializer; expected index
// streams come from a queue of set-bit positions built from each mask.
module tb_bit_scan_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_mask = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_mask;
    logic       busy;

    int total = 0;
    int bad   = 0;

    bit_scan_serializer #(
        .WIDTH (8),
        .IDXW  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_mask (zero_mask),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one mask for one cycle.
    task automatic send(input logic [7:0] m);
        int w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        check("send_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_mask  = m;
        step();
        in_valid = 1'b0;
        check("latency_valid", {31'd0, out_valid}, {31'd0, m != 8'h00});
        check("zero_pulse", {31'd0, zero_mask}, {31'd0, m == 8'h00});
    endtask

    // mode 0: ready always high; 1: ready 0,1,0,1...; 2: random ready.
    // noise keeps in_valid high with changing in_mask while scanning.
    task automatic drain(input logic [7:0] m, input int mode, input bit noise, output int cycles);
        int q[$];
        bit rdy;
        for (int i = 0; i < 8; i++) if (m[i]) q.push_back(i);
        cycles = 0;
        while (q.size() > 0 && cycles < 64) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2) == 1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (noise) begin
                in_valid = 1'b1;
                in_mask  = 8'($urandom);
            end
            check("scan_valid", {31'd0, out_valid}, 32'd1);
            check("scan_in_ready", {31'd0, in_ready}, 32'd0);
            check("scan_idx", {29'd0, out_idx}, q[0]);
            check("scan_last", {31'd0, out_last}, {31'd0, q.size() == 1});
            if (rdy) void'(q.pop_front());
            step();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_timeout", q.size(), 32'd0);
        check("done_valid", {31'd0, out_valid}, 32'd0);
        check("done_in_ready", {31'd0, in_ready}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [7:0] m;
        int mode;

        // Reset values while reset is held.
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_idx", {29'd0, out_idx}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_zero_mask", {31'd0, zero_mask}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // 2, 5, 7 on consecutive cycles.
        send(8'b1010_0100);
        drain(8'b1010_0100, 0, 1'b0, cyc);
        check("a4_cycles", cyc, 32'd3);

        // Zero mask: one pulse, then quiet; back-to-back zeros pulse twice.
        send(8'h00);
        check("zero_no_valid", {31'd0, out_valid}, 32'd0);
        check("zero_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("zero_pulse_end", {31'd0, zero_mask}, 32'd0);
        in_valid = 1'b1;
        in_mask  = 8'h00;
        step();
        check("zero_b2b_1", {31'd0, zero_mask}, 32'd1);
        step();
        in_valid = 1'b0;
        check("zero_b2b_2", {31'd0, zero_mask}, 32'd1);
        step();
        check("zero_b2b_end", {31'd0, zero_mask}, 32'd0);

        // Full mask with alternating stalls: 8 transfers on every other cycle.
        send(8'hFF);
        drain(8'hFF, 1, 1'b0, cyc);
        check("ff_cycles", cyc, 32'd16);

        // Single bit: first valid cycle is also last.
        send(8'h80);
        check("single_idx", {29'd0, out_idx}, 32'd7);
        check("single_last", {31'd0, out_last}, 32'd1);
        drain(8'h80, 0, 1'b0, cyc);
        check("single_cycles", cyc, 32'd1);

        // Abort mid-scan with reset after indices 0 and 1 transfer.
        send(8'h0F);
        out_ready = 1'b1;
        check("abort_idx0", {29'd0, out_idx}, 32'd0);
        step();
        check("abort_idx1", {29'd0, out_idx}, 32'd1);
        step();
        out_ready = 1'b0;
        check("abort_pre_valid", {31'd0, out_valid}, 32'd1);
        check("abort_pre_idx", {29'd0, out_idx}, 32'd2);
        #2 reset = 1'b1;
        #1;
        check("abort_valid_drop", {31'd0, out_valid}, 32'd0);
        check("abort_last", {31'd0, out_last}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0;
        step();
        send(8'h10);
        drain(8'h10, 0, 1'b0, cyc);
        check("post_abort_cycles", cyc, 32'd1);

        // in_valid noise during SCAN must not disturb the accepted mask.
        send(8'b0110_1001);
        drain(8'b0110_1001, 2, 1'b1, cyc);
        check("noise_no_capture_busy", {31'd0, busy}, 32'd0);

        // Randomized masks and ready patterns.
        for (int t = 0; t < 40; t++) begin
            m    = 8'($urandom);
            if (t % 10 == 0) m = 8'h00;
            mode = int'($urandom_range(0, 2));
            send(m);
            if (m == 8'h00) begin
                step();
                check("rand_zero_end", {31'd0, zero_mask}, 32'd0);
            end else begin
                drain(m, mode, t[0], cyc);
                if (mode == 0) check("rand_cycles", cyc, $countones(m));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
